// File: rtl/linear_interpolator_pkg.sv
// Shared definitions for the linear interpolator.
//   DATA_W_DEF     : sample width (two's complement, all fractional bits)
//   LOG2_RATIO_DEF : default log2 of the upsampling ratio
//   state_e        : control FSM encoding
package linear_interpolator_pkg;

  localparam int DATA_W_DEF     = 15;
  localparam int LOG2_RATIO_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_STALL = 2'd3
  } state_e;

endpackage

// File: rtl/linear_interpolator_skid.sv
// One-entry valid/ready input buffer for the interpolator.
//   clk, rst      : clock, synchronous active-high reset
//   in_data/valid : upstream sample and its valid
//   in_ready      : buffer empty, a sample can be taken this clk
//   consume_i     : the interpolator takes nxt_o on this edge
//   nxt_o/nxt_v_o : buffered sample and its valid flag
module interp_skid #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         consume_i,
  output logic [W-1:0] nxt_o,
  output logic         nxt_v_o
);

  logic [W-1:0] nxt_q;
  logic         nxt_v_q;

  // Ready comes only from the flag, so it never depends on in_valid.
  // A transfer needs an empty buffer and a consume needs a full one, so
  // the two can never happen on the same edge.
  assign in_ready = ~nxt_v_q;
  assign nxt_o    = nxt_q;
  assign nxt_v_o  = nxt_v_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      nxt_q   <= '0;
      nxt_v_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      nxt_q   <= in_data;
      nxt_v_q <= 1'b1;
    end else if (consume_i) begin
      nxt_v_q <= 1'b0;
    end
  end

endmodule

// File: rtl/linear_interpolator.sv
// Linear (first-order) upsampler: one output sample per clk, R = 2^LOG2_RATIO
// output clks per input sample.
//   clk, rst   : clock, synchronous active-high reset
//   in_data    : signed input sample
//   in_valid   : in_data valid this clk
//   in_ready   : input buffer empty; transfer on in_valid & in_ready
//   interp_o   : registered interpolated sample, new value every clk
//   seg_o      : 1-clk pulse while interp_o shows a segment start value
//   underrun_o : sticky, set when a segment ends with nothing buffered
module linear_interpolator
  import linear_interpolator_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LOG2_RATIO = LOG2_RATIO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] interp_o,
  output logic              seg_o,
  output logic              underrun_o
);

  localparam int ACC_W = DATA_W + LOG2_RATIO + 1;
  localparam int DLT_W = DATA_W + 1;

  state_e                  state_q;
  logic [DATA_W-1:0]       x1_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [DLT_W-1:0] delta_q;
  logic [LOG2_RATIO-1:0]   k_q;
  logic                    seg_q;
  logic                    und_q;

  logic [DATA_W-1:0]       nxt;
  logic                    nxt_v;
  logic                    consume;
  logic                    seg_start;
  logic                    term;
  logic signed [ACC_W-1:0] x1_sh;
  logic signed [ACC_W-1:0] delta_ext;
  logic signed [DLT_W-1:0] delta_d;
  logic                    acc_unused;

  interp_skid #(.W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .consume_i (consume),
    .nxt_o     (nxt),
    .nxt_v_o   (nxt_v)
  );

  // Terminal phase of a segment (k == R-1).
  assign term = &k_q;

  // nxt_v is the registered flag, so a sample arriving on the terminal clk
  // is not seen until the following clk and the block passes through STALL.
  assign seg_start = nxt_v && ((state_q == S_PRIME) || (state_q == S_STALL) ||
                               ((state_q == S_RUN) && term));
  assign consume   = seg_start || (nxt_v && (state_q == S_IDLE));

  // x1 scaled into the accumulator's fixed-point grid (sign-extended).
  assign x1_sh     = {x1_q[DATA_W-1], x1_q, {LOG2_RATIO{1'b0}}};
  // One extra bit keeps full-scale differences from wrapping.
  assign delta_d   = $signed({nxt[DATA_W-1], nxt}) - $signed({x1_q[DATA_W-1], x1_q});
  assign delta_ext = {{(ACC_W-DLT_W){delta_q[DLT_W-1]}}, delta_q};

  // Dropping the low bits floors; the top guard bit is never needed for the
  // output because the value always lies between the two endpoints.
  assign interp_o   = acc_q[DATA_W+LOG2_RATIO-1:LOG2_RATIO];
  assign seg_o      = seg_q;
  assign underrun_o = und_q;
  assign acc_unused = ^{acc_q[ACC_W-1], acc_q[LOG2_RATIO-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x1_q    <= '0;
      acc_q   <= '0;
      delta_q <= '0;
      k_q     <= '0;
      seg_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      seg_q <= 1'b0;
      if (seg_start) begin
        // New segment from the current endpoint to the buffered sample.
        acc_q   <= x1_sh;
        delta_q <= delta_d;
        x1_q    <= nxt;
        k_q     <= '0;
        seg_q   <= 1'b1;
        state_q <= S_RUN;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (nxt_v) begin
              x1_q    <= nxt;
              state_q <= S_PRIME;
            end
          end
          S_RUN: begin
            if (!term) begin
              acc_q <= acc_q + delta_ext;
              k_q   <= k_q + 1'b1;
            end else begin
              // Nothing buffered at the end of the segment: park on x1.
              acc_q   <= x1_sh;
              delta_q <= '0;
              und_q   <= 1'b1;
              state_q <= S_STALL;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
